// File: rtl/neptuno_joy_reader.sv
// neptuno_joy_reader
//
// Scans the NeptUNO DB9 joystick chain (two 74HC165s in series) and presents
// two active-high button words to the guest core. A scan is a fixed sequence
// of ticks: idle gap, parallel load, 16 shift clocks, and then an output
// update. Outputs change only at the end of a complete scan, so the core never
// sees a partially shifted word.
//
// Build option: define JOY_MD6_EN to add a second pass with JOY_SEL low.
// That pass reads the Mega Drive A/Start buttons. When it is not defined,
// the block does a single pass, JOY_SEL stays at 1 and joyN[7:6] read as 0.
//
// Ports
//   clk        system clock
//   reset      asynchronous, active-high reset
//   JOY_CLK    shift clock to the 74HC165 chain
//   JOY_LOAD   parallel-load strobe to the chain, active-low
//   JOY_SEL    Mega Drive select line
//   JOY_DATA   serial chain output, active-low buttons, asynchronous to clk
//   joy1/joy2  {start, a, c, b, up, down, left, right}, active-high
//   joy_valid  one-clk pulse in the first clk that shows new joy1/joy2
module neptuno_joy_reader #(
    parameter int CLK_DIV      = 16,
    parameter int SETTLE_TICKS = 4,
    parameter int GAP_TICKS    = 64
) (
    input  logic       clk,
    input  logic       reset,
    output logic       JOY_CLK,
    output logic       JOY_LOAD,
    output logic       JOY_SEL,
    input  logic       JOY_DATA,
    output logic [7:0] joy1,
    output logic [7:0] joy2,
    output logic       joy_valid
);

    localparam int DIV_W   = $clog2(CLK_DIV);
    localparam int CNT_MAX = (GAP_TICKS > SETTLE_TICKS) ? GAP_TICKS : SETTLE_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_SETTLE   = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick;
    logic [1:0]       sync_q;
    logic             data_s;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [15:0]      sr_q, sr_d;
    logic             joy_clk_q, joy_clk_d;
    logic             joy_load_q, joy_load_d;
    logic             joy_sel_q, joy_sel_d;
    logic [7:0]       joy1_q, joy1_d;
    logic [7:0]       joy2_q, joy2_d;
    logic             valid_q, valid_d;
`ifdef JOY_MD6_EN
    logic [15:0]      word1_q, word1_d;
`endif

    // Pass-1 byte bits [7:2] (up, down, left, right, B, C; active-low) to
    // {c, b, up, down, left, right}, active-high.
    function automatic logic [5:0] dec_main(input logic [5:0] b);
        return ~{b[0], b[1], b[5], b[4], b[3], b[2]};
    endfunction

`ifdef JOY_MD6_EN
    // Pass-2 byte bits [3:2] (A, Start; active-low) to {start, a}, active-high.
    function automatic logic [1:0] dec_ext(input logic [1:0] b);
        return ~{b[0], b[1]};
    endfunction
`endif

    assign tick       = (tick_cnt_q == DIV_W'(CLK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    assign data_s     = sync_q[1];

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        sr_d       = sr_q;
        joy_clk_d  = joy_clk_q;
        joy_load_d = joy_load_q;
        joy_sel_d  = joy_sel_q;
        joy1_d     = joy1_q;
        joy2_d     = joy2_q;
        valid_d    = 1'b0;
`ifdef JOY_MD6_EN
        word1_d    = word1_q;
`endif
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (cnt_q == CNT_W'(GAP_TICKS - 1)) begin
                        cnt_d      = '0;
                        joy_load_d = 1'b0;
                        state_d    = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_LOAD: begin
                    joy_load_d = 1'b1;
                    bit_d      = 4'd15;
                    state_d    = ST_SHIFT_LO;
                end
                ST_SHIFT_LO: begin
                    // Sampling at the end of the low half-period gives the
                    // chain a full tick to settle after the previous edge.
                    sr_d[bit_q] = data_s;
                    joy_clk_d   = 1'b1;
                    state_d     = ST_SHIFT_HI;
                end
                ST_SHIFT_HI: begin
                    joy_clk_d = 1'b0;
                    if (bit_q == 4'd0) begin
`ifdef JOY_MD6_EN
                        // SEL high means pass 1 just finished: keep its word
                        // and select the extended buttons for pass 2.
                        if (joy_sel_q) begin
                            word1_d = sr_q;
                        end
                        joy_sel_d = ~joy_sel_q;
                        state_d   = ST_SETTLE;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        bit_d   = bit_q - 4'd1;
                        state_d = ST_SHIFT_LO;
                    end
                end
                ST_SETTLE: begin
`ifdef JOY_MD6_EN
                    if (cnt_q == CNT_W'(SETTLE_TICKS - 1)) begin
                        cnt_d = '0;
                        if (joy_sel_q) begin
                            state_d = ST_DONE;
                        end else begin
                            joy_load_d = 1'b0;
                            state_d    = ST_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
                ST_DONE: begin
`ifdef JOY_MD6_EN
                    joy1_d = {dec_ext(sr_q[11:10]), dec_main(word1_q[15:10])};
                    joy2_d = {dec_ext(sr_q[3:2]), dec_main(word1_q[7:2])};
`else
                    joy1_d = {2'b00, dec_main(sr_q[15:10])};
                    joy2_d = {2'b00, dec_main(sr_q[7:2])};
`endif
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= '0;
            // NOTE: the synchroniser and data registers are reset as well, to an idle (all released) chain.
            sync_q     <= 2'b11;
            sr_q       <= '1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_q      <= 4'd15;
            joy_clk_q  <= 1'b0;
            joy_load_q <= 1'b1;
            joy_sel_q  <= 1'b1;
            joy1_q     <= 8'h00;
            joy2_q     <= 8'h00;
            valid_q    <= 1'b0;
`ifdef JOY_MD6_EN
            word1_q    <= '1;
`endif
        end else begin
            tick_cnt_q <= tick_cnt_d;
            sync_q     <= {sync_q[0], JOY_DATA};
            sr_q       <= sr_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            joy_clk_q  <= joy_clk_d;
            joy_load_q <= joy_load_d;
            joy_sel_q  <= joy_sel_d;
            joy1_q     <= joy1_d;
            joy2_q     <= joy2_d;
            valid_q    <= valid_d;
`ifdef JOY_MD6_EN
            word1_q    <= word1_d;
`endif
        end
    end

    // Chain bits that carry no button in this build are shifted in and dropped.
    logic unused_bits;
`ifdef JOY_MD6_EN
    assign unused_bits = ^{sr_q[15:12], sr_q[9:4], sr_q[1:0], word1_q[9:8], word1_q[1:0]};
`else
    assign unused_bits = ^{sr_q[9:8], sr_q[1:0]};
`endif

    assign JOY_CLK   = joy_clk_q;
    assign JOY_LOAD  = joy_load_q;
    assign JOY_SEL   = joy_sel_q;
    assign joy1      = joy1_q;
    assign joy2      = joy2_q;
    assign joy_valid = valid_q;

endmodule
